// File: rtl/uart_rx_deserializer_if.sv
// Bundles the UART receive line, frame configuration and received-word status.
// master is the deserializer side; slave is the line driver / word consumer side.
interface uart_rx_deserializer_if;
  logic       baud_tick;
  logic       rx_in;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       data_length;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_error;
  logic       stop_error;
  logic       rx_active;

  modport master (
    input  baud_tick, rx_in, parity_type, stop_bits, data_length,
    output data_out, data_valid, parity_error, stop_error, rx_active
  );

  modport slave (
    output baud_tick, rx_in, parity_type, stop_bits, data_length,
    input  data_out, data_valid, parity_error, stop_error, rx_active
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receiver: oversamples a synchronized rx line and recovers start/7-8 data/parity/1-2 stop
// frames, reporting the word with parity and framing status.
module uart_rx_deserializer #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clock,
  input  logic                          rst,
  uart_rx_deserializer_if.master        rx_if
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } state_t;

  state_t                 state_q, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [CW-1:0]          scnt_q, scnt_n;
  logic [2:0]             bit_q, bit_n;
  logic [7:0]             shift_q, shift_n;
  logic                   stop_cnt_q, stop_cnt_n;
  logic                   par_err_q, par_err_n;
  logic                   stop_err_q, stop_err_n;
  logic                   wait_high_q, wait_high_n;
  logic [1:0]             cfg_par_q, cfg_par_n;
  logic                   cfg_two_q, cfg_two_n;
  logic                   cfg_len_q, cfg_len_n;
  logic [7:0]             data_out_q, data_out_n;
  logic                   data_valid_q, data_valid_n;
  logic                   parity_error_q, parity_error_n;
  logic                   stop_error_q, stop_error_n;
  logic                   rx_active_q, rx_active_n;

  logic                   parity_en;
  logic                   parity_odd;
  logic [2:0]             last_bit;
  logic [7:0]             data_word;
  logic                   mid_bit;

  assign rx_s       = sync_q[SYNC_STAGES-1];
  assign parity_en  = cfg_par_q[0] ^ cfg_par_q[1];
  assign parity_odd = (cfg_par_q == 2'b01);
  assign last_bit   = cfg_len_q ? 3'd7 : 3'd6;
  // A 7-bit word ends up in shift_q[7:1] because bits always enter at the MSB.
  assign data_word  = cfg_len_q ? shift_q : {1'b0, shift_q[7:1]};
  assign mid_bit    = rx_if.baud_tick && (scnt_q == FULL_LAST);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_if.rx_in};
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      scnt_q         <= '0;
      bit_q          <= '0;
      shift_q        <= '0;
      stop_cnt_q     <= 1'b0;
      par_err_q      <= 1'b0;
      stop_err_q     <= 1'b0;
      wait_high_q    <= 1'b0;
      cfg_par_q      <= '0;
      cfg_two_q      <= 1'b0;
      cfg_len_q      <= 1'b0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
      rx_active_q    <= 1'b0;
    end else begin
      state_q        <= state_n;
      scnt_q         <= scnt_n;
      bit_q          <= bit_n;
      shift_q        <= shift_n;
      stop_cnt_q     <= stop_cnt_n;
      par_err_q      <= par_err_n;
      stop_err_q     <= stop_err_n;
      wait_high_q    <= wait_high_n;
      cfg_par_q      <= cfg_par_n;
      cfg_two_q      <= cfg_two_n;
      cfg_len_q      <= cfg_len_n;
      data_out_q     <= data_out_n;
      data_valid_q   <= data_valid_n;
      parity_error_q <= parity_error_n;
      stop_error_q   <= stop_error_n;
      rx_active_q    <= rx_active_n;
    end
  end

  always_comb begin
    state_n        = state_q;
    scnt_n         = scnt_q;
    bit_n          = bit_q;
    shift_n        = shift_q;
    stop_cnt_n     = stop_cnt_q;
    par_err_n      = par_err_q;
    stop_err_n     = stop_err_q;
    wait_high_n    = wait_high_q;
    cfg_par_n      = cfg_par_q;
    cfg_two_n      = cfg_two_q;
    cfg_len_n      = cfg_len_q;
    data_out_n     = data_out_q;
    data_valid_n   = 1'b0;
    parity_error_n = parity_error_q;
    stop_error_n   = stop_error_q;

    unique case (state_q)
      IDLE: begin
        // After a framing error or break the line must return high before a start is trusted.
        if (rx_if.baud_tick) begin
          if (wait_high_q) begin
            if (rx_s) wait_high_n = 1'b0;
          end else if (!rx_s) begin
            state_n    = START;
            scnt_n     = '0;
            par_err_n  = 1'b0;
            stop_err_n = 1'b0;
            cfg_par_n  = rx_if.parity_type;
            cfg_two_n  = rx_if.stop_bits;
            cfg_len_n  = rx_if.data_length;
          end
        end
      end

      START: begin
        if (rx_if.baud_tick) begin
          if (scnt_q == HALF_LAST) begin
            scnt_n = '0;
            if (rx_s) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              bit_n   = '0;
            end
          end else begin
            scnt_n = scnt_q + CW'(1);
          end
        end
      end

      DATA: begin
        if (mid_bit) begin
          scnt_n  = '0;
          shift_n = {rx_s, shift_q[7:1]};
          if (bit_q == last_bit) begin
            state_n    = parity_en ? PARITY : STOP;
            stop_cnt_n = 1'b0;
          end else begin
            bit_n = bit_q + 3'd1;
          end
        end else if (rx_if.baud_tick) begin
          scnt_n = scnt_q + CW'(1);
        end
      end

      PARITY: begin
        if (mid_bit) begin
          scnt_n    = '0;
          par_err_n = ((^data_word) ^ rx_s) != parity_odd;
          state_n   = STOP;
        end else if (rx_if.baud_tick) begin
          scnt_n = scnt_q + CW'(1);
        end
      end

      STOP: begin
        if (mid_bit) begin
          scnt_n = '0;
          if (!rx_s) stop_err_n = 1'b1;
          if (stop_cnt_q == cfg_two_q) begin
            state_n = DONE;
          end else begin
            stop_cnt_n = 1'b1;
          end
        end else if (rx_if.baud_tick) begin
          scnt_n = scnt_q + CW'(1);
        end
      end

      DONE: begin
        data_out_n     = data_word;
        parity_error_n = par_err_q;
        stop_error_n   = stop_err_q;
        data_valid_n   = 1'b1;
        wait_high_n    = stop_err_q;
        state_n        = IDLE;
      end

      default: state_n = IDLE;
    endcase

    rx_active_n = (state_n != IDLE);
  end

  assign rx_if.data_out     = data_out_q;
  assign rx_if.data_valid   = data_valid_q;
  assign rx_if.parity_error = parity_error_q;
  assign rx_if.stop_error   = stop_error_q;
  assign rx_if.rx_active    = rx_active_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: sends hand-built frames at 16 ticks/bit, one tick
// every 4 clocks, and checks the captured word and status against hand-computed values.
module tb_uart_rx_deserializer;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLKS = 16 * TICK_DIV;

  logic clock;
  logic rst;
  uart_rx_deserializer_if rif ();

  uart_rx_deserializer #(
    .OVERSAMPLE (16),
    .SYNC_STAGES(2)
  ) dut (
    .clock(clock),
    .rst  (rst),
    .rx_if(rif)
  );

  int vectors     = 0;
  int miscompares = 0;
  int vldCount    = 0;
  int widthErr    = 0;
  int tickCnt     = 0;
  int base;
  logic       prevValid = 1'b0;
  logic [7:0] lastData;
  logic       lastPe;
  logic       lastSe;
  logic [7:0] rxLog[$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    tickCnt       = (tickCnt + 1) % TICK_DIV;
    rif.baud_tick = (tickCnt == 0);
  end

  // Capture every received word and flag any data_valid wider than one clock.
  always @(negedge clock) begin
    if (rst && rif.data_valid) begin
      vldCount++;
      lastData = rif.data_out;
      lastPe   = rif.parity_error;
      lastSe   = rif.stop_error;
      rxLog.push_back(rif.data_out);
      if (prevValid) widthErr++;
    end
    prevValid = rif.data_valid;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic sendBit(input logic v);
    rif.rx_in = v;
    repeat (BIT_CLKS) @(negedge clock);
  endtask

  task automatic idleBits(input int n);
    rif.rx_in = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clock);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic len8, input logic [1:0] ptype,
                               input logic twoStop, input logic flipParity, input logic stopLow);
    logic [7:0] dbits;
    logic       p;
    rif.parity_type = ptype;
    rif.stop_bits   = twoStop;
    rif.data_length = len8;
    dbits = len8 ? data : {1'b0, data[6:0]};
    sendBit(1'b0);
    for (int i = 0; i < (len8 ? 8 : 7); i++) sendBit(dbits[i]);
    if (ptype == 2'b01 || ptype == 2'b10) begin
      p = (ptype == 2'b10) ? (^dbits) : ~(^dbits);
      sendBit(p ^ flipParity);
    end
    sendBit(!stopLow);
    if (twoStop) sendBit(1'b1);
  endtask

  initial begin
    rst             = 1'b0;
    rif.rx_in       = 1'b1;
    rif.baud_tick   = 1'b0;
    rif.parity_type = 2'b00;
    rif.stop_bits   = 1'b0;
    rif.data_length = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("reset data_out", rif.data_out, 8'h00);
    checkOutput("reset data_valid", rif.data_valid, 1'b0);
    checkOutput("reset rx_active", rif.rx_active, 1'b0);
    checkOutput("reset errors", {rif.parity_error, rif.stop_error}, 2'b00);
    rst = 1'b1;
    idleBits(1);

    // 8N1 0x55
    base = vldCount;
    applyStimulus(8'h55, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    idleBits(1);
    checkOutput("8N1 count", vldCount - base, 1);
    checkOutput("8N1 data", lastData, 8'h55);
    checkOutput("8N1 errors", {lastPe, lastSe}, 2'b00);

    // 7E2 0x41, correct then flipped parity
    base = vldCount;
    applyStimulus(8'h41, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0);
    idleBits(1);
    checkOutput("7E2 count", vldCount - base, 1);
    checkOutput("7E2 data", lastData, 8'h41);
    checkOutput("7E2 errors", {lastPe, lastSe}, 2'b00);
    applyStimulus(8'h41, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0);
    idleBits(1);
    checkOutput("7E2 flip data", lastData, 8'h41);
    checkOutput("7E2 flip errors", {lastPe, lastSe}, 2'b10);

    // reset in the middle of the data bits
    rif.parity_type = 2'b00;
    rif.stop_bits   = 1'b0;
    rif.data_length = 1'b1;
    sendBit(1'b0);
    sendBit(1'b0);
    sendBit(1'b1);
    checkOutput("pre-reset rx_active", rif.rx_active, 1'b1);
    rst = 1'b0;
    #1;
    checkOutput("midrst data_out", rif.data_out, 8'h00);
    checkOutput("midrst valid/active", {rif.data_valid, rif.rx_active}, 2'b00);
    checkOutput("midrst errors", {rif.parity_error, rif.stop_error}, 2'b00);
    rif.rx_in = 1'b1;
    repeat (3) @(negedge clock);
    rst  = 1'b1;
    base = vldCount;
    idleBits(2);
    checkOutput("midrst no frame", vldCount - base, 0);
    applyStimulus(8'h7E, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    idleBits(1);
    checkOutput("post-rst count", vldCount - base, 1);
    checkOutput("post-rst data", lastData, 8'h7E);
    checkOutput("post-rst errors", {lastPe, lastSe}, 2'b00);

    // start glitch
    base = vldCount;
    rif.rx_in = 1'b0;
    repeat (12) @(negedge clock);
    checkOutput("glitch active", rif.rx_active, 1'b1);
    repeat (4) @(negedge clock);
    rif.rx_in = 1'b1;
    repeat (BIT_CLKS) @(negedge clock);
    checkOutput("glitch inactive", rif.rx_active, 1'b0);
    checkOutput("glitch no frame", vldCount - base, 0);

    // 8O1 0xA3 with stop bit low
    base = vldCount;
    applyStimulus(8'hA3, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
    idleBits(2);
    checkOutput("8O1 count", vldCount - base, 1);
    checkOutput("8O1 data", lastData, 8'hA3);
    checkOutput("8O1 errors", {lastPe, lastSe}, 2'b01);

    // break: line low for two frame times
    base = vldCount;
    rif.rx_in = 1'b0;
    repeat (22 * BIT_CLKS) @(negedge clock);
    checkOutput("break count", vldCount - base, 1);
    checkOutput("break data", lastData, 8'h00);
    checkOutput("break errors", {lastPe, lastSe}, 2'b11);
    checkOutput("break idle", rif.rx_active, 1'b0);
    idleBits(2);
    checkOutput("break release", vldCount - base, 1);

    // back-to-back 8N1 frames
    base = vldCount;
    applyStimulus(8'h12, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h34, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    idleBits(1);
    checkOutput("b2b count", vldCount - base, 2);
    checkOutput("b2b first", rxLog[rxLog.size() - 2], 8'h12);
    checkOutput("b2b second", rxLog[rxLog.size() - 1], 8'h34);
    checkOutput("b2b errors", {lastPe, lastSe}, 2'b00);

    checkOutput("valid width", widthErr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
